// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
//   Shared definitions for the boot-time instruction memory loader.
//   Contents:
//     INSTR_W            instruction word width of the 16-bit CPU
//     SYNC_BYTE_DEFAULT  default frame start marker
//     state_t            loader FSM state encoding
//     in_frame()         true for states where a frame is in progress and
//                        the idle timeout applies
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  localparam int         INSTR_W           = 16;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LEN_HI  = 4'd1,
    S_LEN_LO  = 4'd2,
    S_DATA_HI = 4'd3,
    S_DATA_LO = 4'd4,
    S_WRITE   = 4'd5,
    S_CHECK   = 4'd6,
    S_DONE    = 4'd7,
    S_ERROR   = 4'd8
  } state_t;

  // Frame-in-progress states: LEN_HI through CHECK. The idle counter only
  // runs here; IDLE, ERROR and DONE wait indefinitely.
  function automatic logic in_frame(input state_t s);
    return (s == S_LEN_HI)  || (s == S_LEN_LO)  || (s == S_DATA_HI) ||
           (s == S_DATA_LO) || (s == S_WRITE)   || (s == S_CHECK);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
//   Groups the byte-stream handshake (from the UART receiver) and the
//   instruction memory write port driven by the loader.
//   Signals:
//     rx_valid    receiver has a byte on rx_data
//     rx_data     received byte
//     rx_ready    loader can take a byte (transfer on rx_valid & rx_ready)
//     imem_we     one-cycle instruction memory write strobe
//     imem_addr   even byte address of the write
//     imem_wdata  instruction word
//   Modports:
//     master  the loader side (consumes bytes, drives the write port)
//     slave   the environment side (receiver + instruction memory)
// -----------------------------------------------------------------------------
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 16
) ();

  logic                rx_valid;
  logic [7:0]          rx_data;
  logic                rx_ready;
  logic                imem_we;
  logic [ADDR_W-1:0]   imem_addr;
  logic [INSTR_W-1:0]  imem_wdata;

  modport master (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport slave (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

endinterface

// File: rtl/imem_loader_timer.sv
// -----------------------------------------------------------------------------
// imem_loader_timer
//   Idle-cycle counter for the loader. Counts cycles while enabled, is
//   reloaded to zero by clear, and saturates at LIMIT.
//   Ports:
//     clk      clock, rising edge
//     reset    asynchronous, active-high
//     clear    reload count to zero (takes priority over enable)
//     enable   count this cycle
//     expired  count has reached LIMIT
// -----------------------------------------------------------------------------
module imem_loader_timer #(
  parameter int LIMIT = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      // Saturate so a long stall cannot wrap back to a non-expired count.
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = (count_reg == CNT_W'(LIMIT));

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Boot-time program loader in front of the CPU instruction memory.
//   Receives frames  SYNC, LEN_HI, LEN_LO, {W_HI, W_LO} x LEN, CHK
//   (CHK = XOR of every byte after SYNC), writes each word to byte address
//   0, 2, 4, ... and releases the CPU from reset once a frame completes with
//   a matching checksum.
//   Ports:
//     clk        clock, rising edge
//     reset      asynchronous, active-high
//     bus        imem_loader_if.master: rx_* byte handshake, imem_* write port
//     cpu_reset  high while the CPU must be held in reset
//     load_done  sticky: a frame loaded with a good checksum
//     load_err   set when a frame fails, cleared by the next SYNC
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W         = 16,
  parameter int         MAX_WORDS      = 256,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 65535
) (
  input  logic                clk,
  input  logic                reset,
  imem_loader_if.master       bus,
  output logic                cpu_reset,
  output logic                load_done,
  output logic                load_err
);

  state_t              state_reg;
  logic [7:0]          chk_reg;
  logic [7:0]          len_hi_reg;
  logic [15:0]         len_reg;
  logic [7:0]          w_hi_reg;
  logic [ADDR_W-2:0]   word_idx_reg;

  logic                rx_ready_reg;
  logic                imem_we_reg;
  logic [ADDR_W-1:0]   imem_addr_reg;
  logic [INSTR_W-1:0]  imem_wdata_reg;
  logic                cpu_reset_reg;
  logic                load_done_reg;
  logic                load_err_reg;

  logic                byte_accept;
  logic [15:0]         len_next;
  logic [31:0]         idx_plus1;
  logic                frame_active;
  logic                timer_expired;

  assign byte_accept  = bus.rx_valid && rx_ready_reg;
  assign len_next     = {len_hi_reg, bus.rx_data};
  assign idx_plus1    = 32'(word_idx_reg) + 32'd1;
  assign frame_active = in_frame(state_reg);

  // Idle counter restarts on every accepted byte and is held at zero
  // whenever no frame is in progress.
  imem_loader_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (byte_accept || !frame_active),
    .enable  (frame_active),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      chk_reg        <= '0;
      len_hi_reg     <= '0;
      len_reg        <= '0;
      w_hi_reg       <= '0;
      word_idx_reg   <= '0;
      rx_ready_reg   <= 1'b1;
      imem_we_reg    <= 1'b0;
      imem_addr_reg  <= '0;
      imem_wdata_reg <= '0;
      cpu_reset_reg  <= 1'b1;
      load_done_reg  <= 1'b0;
      load_err_reg   <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse; rx_ready drops only for the
      // WRITE cycle and is re-asserted by default everywhere else.
      imem_we_reg  <= 1'b0;
      rx_ready_reg <= 1'b1;

      if (frame_active && timer_expired) begin
        state_reg    <= S_ERROR;
        load_err_reg <= 1'b1;
      end else begin
        case (state_reg)
          S_IDLE, S_ERROR: begin
            if (byte_accept && (bus.rx_data == SYNC_BYTE)) begin
              state_reg    <= S_LEN_HI;
              chk_reg      <= '0;
              word_idx_reg <= '0;
              load_err_reg <= 1'b0;
            end
          end

          S_LEN_HI: begin
            if (byte_accept) begin
              len_hi_reg <= bus.rx_data;
              chk_reg    <= chk_reg ^ bus.rx_data;
              state_reg  <= S_LEN_LO;
            end
          end

          S_LEN_LO: begin
            if (byte_accept) begin
              len_reg <= len_next;
              chk_reg <= chk_reg ^ bus.rx_data;
              if (len_next == 16'd0) begin
                state_reg <= S_CHECK;
              end else if (32'(len_next) > 32'(MAX_WORDS)) begin
                state_reg    <= S_ERROR;
                load_err_reg <= 1'b1;
              end else begin
                state_reg <= S_DATA_HI;
              end
            end
          end

          S_DATA_HI: begin
            if (byte_accept) begin
              w_hi_reg  <= bus.rx_data;
              chk_reg   <= chk_reg ^ bus.rx_data;
              state_reg <= S_DATA_LO;
            end
          end

          S_DATA_LO: begin
            if (byte_accept) begin
              chk_reg        <= chk_reg ^ bus.rx_data;
              state_reg      <= S_WRITE;
              // Write port outputs are registered here so they are valid for
              // exactly the WRITE cycle.
              imem_we_reg    <= 1'b1;
              imem_addr_reg  <= {word_idx_reg, 1'b0};
              imem_wdata_reg <= {w_hi_reg, bus.rx_data};
              rx_ready_reg   <= 1'b0;
            end
          end

          S_WRITE: begin
            word_idx_reg <= word_idx_reg + 1'b1;
            if (idx_plus1 < 32'(len_reg)) begin
              state_reg <= S_DATA_HI;
            end else begin
              state_reg <= S_CHECK;
            end
          end

          S_CHECK: begin
            if (byte_accept) begin
              if (bus.rx_data == chk_reg) begin
                state_reg     <= S_DONE;
                cpu_reset_reg <= 1'b0;
                load_done_reg <= 1'b1;
              end else begin
                state_reg    <= S_ERROR;
                load_err_reg <= 1'b1;
              end
            end
          end

          S_DONE: begin
            // Terminal until reset; incoming bytes are accepted and dropped.
          end

          default: begin
            state_reg <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.rx_ready   = rx_ready_reg;
  assign bus.imem_we    = imem_we_reg;
  assign bus.imem_addr  = imem_addr_reg;
  assign bus.imem_wdata = imem_wdata_reg;
  assign cpu_reset      = cpu_reset_reg;
  assign load_done      = load_done_reg;
  assign load_err       = load_err_reg;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Self-checking bench for imem_loader: a table of framed byte streams with
//   hand-computed expected writes and status, plus hand-written sequences
//   for reset, the maximum-length frame, the idle timeout and reset mid-frame.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int TIMEOUT = 65535;
  localparam int NVEC    = 9;

  logic clk;
  logic reset;
  logic cpu_reset;
  logic load_done;
  logic load_err;

  int checks = 0;
  int errors = 0;

  imem_loader_if #(.ADDR_W(16)) bus ();

  imem_loader #(
    .ADDR_W         (16),
    .MAX_WORDS      (256),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .load_done (load_done),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: logs every write strobe together with rx_ready in that cycle.
  int          wr_count = 0;
  logic [15:0] wr_addr  [0:1023];
  logic [15:0] wr_data  [0:1023];
  logic        wr_ready [0:1023];

  always @(posedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_addr[wr_count % 1024]  <= bus.imem_addr;
      wr_data[wr_count % 1024]  <= bus.imem_wdata;
      wr_ready[wr_count % 1024] <= bus.rx_ready;
      wr_count                  <= wr_count + 1;
    end
  end

  typedef struct {
    logic        rst_first;
    int          nb;
    logic [95:0] stream;   // bytes right-aligned, first byte leftmost
    int          nw;
    logic [47:0] wa;       // up to 3 addresses, first leftmost
    logic [47:0] wd;       // up to 3 data words, first leftmost
    logic        done;
    logic        err;
  } vec_t;

  vec_t vecs [0:NVEC-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (bus.rx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rx_ready_wait", {31'd0, bus.rx_ready}, 32'd1);
    @(posedge clk);
  endtask

  task automatic go_idle(input int n);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_status(input string tag, input logic done, input logic err);
    check({tag, "_load_done"}, {31'd0, load_done}, {31'd0, done});
    check({tag, "_load_err"},  {31'd0, load_err},  {31'd0, err});
    check({tag, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, ~done});
  endtask

  int base;
  int nw;

  initial begin
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Good frame: chk = 00^02^12^34^AB^CD = 42
    vecs[0] = '{1'b1, 8, 96'({8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42}),
                2, {16'h0000, 16'h0002, 16'h0000}, {16'h1234, 16'hABCD, 16'h0000}, 1'b1, 1'b0};
    // Bad checksum: words still written
    vecs[1] = '{1'b1, 8, 96'({8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43}),
                2, {16'h0000, 16'h0002, 16'h0000}, {16'h1234, 16'hABCD, 16'h0000}, 1'b0, 1'b1};
    // Resend from ERROR: SYNC clears load_err, frame completes
    vecs[2] = '{1'b0, 8, 96'({8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42}),
                2, {16'h0000, 16'h0002, 16'h0000}, {16'h1234, 16'hABCD, 16'h0000}, 1'b1, 1'b0};
    // Bytes after DONE are discarded
    vecs[3] = '{1'b0, 6, 96'({8'hA5, 8'h00, 8'h01, 8'h55, 8'h66, 8'h33}),
                0, 48'd0, 48'd0, 1'b1, 1'b0};
    // LEN = 257 exceeds MAX_WORDS
    vecs[4] = '{1'b1, 3, 96'({8'hA5, 8'h01, 8'h01}),
                0, 48'd0, 48'd0, 1'b0, 1'b1};
    // LEN = 0 from ERROR, chk = 00
    vecs[5] = '{1'b0, 4, 96'({8'hA5, 8'h00, 8'h00, 8'h00}),
                0, 48'd0, 48'd0, 1'b1, 1'b0};
    // Leading junk, then one word; chk = 00^01^BE^EF = 50
    vecs[6] = '{1'b1, 8, 96'({8'h00, 8'h5A, 8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h50}),
                1, {16'h0000, 16'h0000, 16'h0000}, {16'hBEEF, 16'h0000, 16'h0000}, 1'b1, 1'b0};
    // Three words; chk = 00^03 = 03
    vecs[7] = '{1'b1, 10, 96'({8'hA5, 8'h00, 8'h03, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h03}),
                3, {16'h0000, 16'h0002, 16'h0004}, {16'h1111, 16'h2222, 16'h3333}, 1'b1, 1'b0};
    // One word, bad checksum (good would be FE)
    vecs[8] = '{1'b1, 6, 96'({8'hA5, 8'h00, 8'h01, 8'hFF, 8'h00, 8'h00}),
                1, {16'h0000, 16'h0000, 16'h0000}, {16'hFF00, 16'h0000, 16'h0000}, 1'b0, 1'b1};

    // Reset state, during and after reset
    repeat (2) @(negedge clk);
    check("rst_in_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
    check("rst_in_imem_we",  {31'd0, bus.imem_we},  32'd0);
    check_status("rst_in", 1'b0, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rx_ready",   {31'd0, bus.rx_ready}, 32'd1);
    check("rst_imem_we",    {31'd0, bus.imem_we},  32'd0);
    check("rst_imem_addr",  {16'd0, bus.imem_addr},  32'd0);
    check("rst_imem_wdata", {16'd0, bus.imem_wdata}, 32'd0);
    check_status("rst", 1'b0, 1'b0);
    check("rst_no_writes", wr_count, 0);
    $display("reset: cpu_reset=%0b rx_ready=%0b load_done=%0b load_err=%0b",
             cpu_reset, bus.rx_ready, load_done, load_err);

    // Table-driven frames
    for (int v = 0; v < NVEC; v++) begin
      if (vecs[v].rst_first) do_reset();
      base = wr_count;
      for (int i = 0; i < vecs[v].nb; i++) begin
        send_byte(vecs[v].stream[(vecs[v].nb - 1 - i) * 8 +: 8]);
      end
      go_idle(8);
      nw = wr_count - base;
      check($sformatf("v%0d_nwrites", v), nw, vecs[v].nw);
      for (int i = 0; i < vecs[v].nw && i < nw; i++) begin
        check($sformatf("v%0d_w%0d_addr", v, i), {16'd0, wr_addr[(base + i) % 1024]},
              {16'd0, vecs[v].wa[(2 - i) * 16 +: 16]});
        check($sformatf("v%0d_w%0d_data", v, i), {16'd0, wr_data[(base + i) % 1024]},
              {16'd0, vecs[v].wd[(2 - i) * 16 +: 16]});
        check($sformatf("v%0d_w%0d_rx_ready", v, i), {31'd0, wr_ready[(base + i) % 1024]}, 32'd0);
      end
      check_status($sformatf("v%0d", v), vecs[v].done, vecs[v].err);
      $display("vec %0d: bytes=%0d writes=%0d load_done=%0b load_err=%0b cpu_reset=%0b",
               v, vecs[v].nb, nw, load_done, load_err, cpu_reset);
    end

    // Maximum legal length: LEN = 256, word i = 0x00ii; chk = 01^00 ^ (XOR 0..255 = 0) = 01
    do_reset();
    base = wr_count;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'h00);
      send_byte(8'(i));
    end
    send_byte(8'h01);
    go_idle(8);
    nw = wr_count - base;
    check("max_nwrites", nw, 256);
    for (int i = 0; i < 256 && i < nw; i++) begin
      check($sformatf("max_w%0d_addr", i), {16'd0, wr_addr[(base + i) % 1024]}, 32'(2 * i));
      check($sformatf("max_w%0d_data", i), {16'd0, wr_data[(base + i) % 1024]}, 32'(i));
    end
    check_status("max", 1'b1, 1'b0);
    $display("max frame: writes=%0d load_done=%0b load_err=%0b", nw, load_done, load_err);

    // Idle timeout inside a frame, after leading junk bytes
    do_reset();
    base = wr_count;
    send_byte(8'h00);
    send_byte(8'h5A);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h12);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (TIMEOUT - 10) @(negedge clk);
    check("tmo_early_load_err", {31'd0, load_err}, 32'd0);
    repeat (20) @(negedge clk);
    check("tmo_nwrites", wr_count - base, 0);
    check_status("tmo", 1'b0, 1'b1);
    $display("timeout: writes=%0d load_err=%0b cpu_reset=%0b", wr_count - base, load_err, cpu_reset);

    // Reset asserted while in DATA_LO: outputs return to reset values at once
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'hAB);
    @(negedge clk);
    check("mid_pre_wdata", {16'd0, bus.imem_wdata}, 32'h1234);
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    #1;
    check("mid_rst_wdata",    {16'd0, bus.imem_wdata}, 32'd0);
    check("mid_rst_addr",     {16'd0, bus.imem_addr},  32'd0);
    check("mid_rst_imem_we",  {31'd0, bus.imem_we},    32'd0);
    check("mid_rst_rx_ready", {31'd0, bus.rx_ready},   32'd1);
    check_status("mid_rst", 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    base  = wr_count;
    repeat (10) @(negedge clk);
    check("mid_after_nwrites", wr_count - base, 0);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hBE);
    send_byte(8'hEF);
    send_byte(8'h50);
    go_idle(8);
    nw = wr_count - base;
    check("mid_new_nwrites", nw, 1);
    if (nw >= 1) begin
      check("mid_new_addr", {16'd0, wr_addr[base % 1024]}, 32'h0000);
      check("mid_new_data", {16'd0, wr_data[base % 1024]}, 32'hBEEF);
    end
    check_status("mid_new", 1'b1, 1'b0);
    $display("reset mid-frame: writes after release=%0d load_done=%0b", nw, load_done);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
